fifo_ctrl: RTL and testbench

Pointer and flag controller for the TLP FIFO. It sits directly upstream of the FIFO's 8×4 dual-port RAM and converts push/pop requests into the RAM's write-enable, read-enable and address signals. It tracks occupancy, raises full/empty/almost flags and error flags, and marks when RAM read data is valid. One `fifo_ctrl` plus one RAM forms a complete FIFO.

---
 rtl/fifo_ctrl_pkg.sv | 10 +
 rtl/fifo_ctrl_if.sv | 35 +++
 rtl/fifo_ctrl_ptr.sv | 21 ++
 rtl/fifo_ctrl.sv | 98 +++++++++
 tb/tb_fifo_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the TLP FIFO pointer/flag controller.
package fifo_pkg;

   localparam int DEF_ADDR_W    = 3;
   localparam int DEF_DEPTH     = 1 << DEF_ADDR_W;
   localparam int DEF_CNT_W     = DEF_ADDR_W + 1;
   localparam int DEF_AF_THRESH = 6;
   localparam int DEF_AE_THRESH = 2;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request, RAM-control and status bundle between the FIFO user side and fifo_ctrl.
interface fifo_ctrl_if #(
   parameter int ADDR_W = fifo_pkg::DEF_ADDR_W
);

   logic              push;
   logic              pop;
   logic              we_a;
   logic [ADDR_W-1:0] addr_a;
   logic              re_b;
   logic [ADDR_W-1:0] addr_b;
   logic              valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              err_overflow;
   logic              err_underflow;

   // User side: issues requests, observes RAM controls and status.
   modport master (
      output push, pop,
      input  we_a, addr_a, re_b, addr_b, valid, full, empty,
             almost_full, almost_empty, count, err_overflow, err_underflow
   );

   // Controller side.
   modport slave (
      input  push, pop,
      output we_a, addr_a, re_b, addr_b, valid, full, empty,
             almost_full, almost_empty, count, err_overflow, err_underflow
   );

endinterface

// File: rtl/fifo_ctrl_ptr.sv
// Wrapping pointer register with increment enable; wraps through 2^W naturally.
module fifo_ptr #(
   parameter int W = fifo_pkg::DEF_ADDR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Pointer register: cleared on reset, advances by one when enabled.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (reset)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for an 8-entry FIFO built around a dual-port RAM.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int AF_THRESH = DEF_AF_THRESH,
   parameter int AE_THRESH = DEF_AE_THRESH
) (
   input  logic       clk,
   input  logic       reset,
   fifo_ctrl_if.slave bus
);

   localparam int                 CNT_W    = ADDR_W + 1;
   localparam int                 DEPTH    = 1 << ADDR_W;
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   AF_CNT   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0]   AE_CNT   = CNT_W'(AE_THRESH);

   logic [CNT_W-1:0]  count_q;
   logic              valid_q;
   logic              ovf_q;
   logic              unf_q;
   logic              full;
   logic              empty;
   logic              push_ok;
   logic              pop_ok;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   // Flags come only from the registered count, so push/pop never reach them.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      full  = 1'b0;
      empty = 1'b0;
      if (count_q == FULL_CNT) full  = 1'b1;
      if (count_q == '0)       empty = 1'b1;
   end

   // Accept decode; a pop frees a slot so push+pop is accepted when full.
   // Reset suppresses both so no RAM write happens during a reset cycle.
   always_comb begin
      push_ok = bus.push & (~full | bus.pop) & ~reset;
      pop_ok  = bus.pop & ~empty & ~reset;
   end

   fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (push_ok),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (pop_ok),
      .ptr   (rd_ptr)
   );

   // Occupancy: moves only when exactly one side is accepted.
   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else if (push_ok && !pop_ok)
         count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok)
         count_q <= count_q - 1'b1;
   end

   // Read-data valid and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         valid_q <= pop_ok;
         if (bus.push && full && !bus.pop) ovf_q <= 1'b1;
         if (bus.pop && empty)             unf_q <= 1'b1;
      end
   end

   assign bus.we_a          = push_ok;
   assign bus.re_b          = pop_ok;
   assign bus.addr_a        = wr_ptr;
   assign bus.addr_b        = rd_ptr;
   assign bus.valid         = valid_q;
   assign bus.count         = count_q;
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.almost_full   = (count_q >= AF_CNT);
   assign bus.almost_empty  = (count_q <= AE_CNT);
   assign bus.err_overflow  = ovf_q;
   assign bus.err_underflow = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural 8x4 registered-read RAM.
module tb_fifo_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] wdata;
   logic [3:0] q_b;
   logic [3:0] mem [8];

   int checks = 0;
   int errors = 0;

   logic [3:0] store_q [$];   // words currently held by the FIFO
   logic [3:0] exp_q   [$];   // words expected on q_b, in order
   logic [2:0] wp;
   logic [2:0] rp;

   typedef struct {
      logic       push;
      logic       pop;
      logic [3:0] data;
      logic       we;
      logic       re;
      int         cnt;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vecs [$];

   fifo_ctrl_if #(.ADDR_W(3)) bus ();

   fifo_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RAM: registered read precedes the write at the same address.
   always @(posedge clk) begin
      if (bus.re_b) q_b <= mem[bus.addr_b];
      if (bus.we_a) mem[bus.addr_a] <= wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check RAM controls before the edge,
   // then check registered state and scoreboard data after it.
   task automatic step(input logic p, input logic q, input logic [3:0] d,
                       input logic ew, input logic er, input int ec,
                       input logic eovf, input logic eunf);
      @(negedge clk);
      bus.push = p;
      bus.pop  = q;
      wdata    = d;
      #1;
      check("we_a", bus.we_a, ew);
      check("re_b", bus.re_b, er);
      if (er) begin
         if (store_q.size() > 0) exp_q.push_back(store_q.pop_front());
         rp++;
      end
      if (ew) begin
         store_q.push_back(d);
         wp++;
      end
      @(posedge clk);
      #1;
      check("count",         bus.count,         ec);
      check("full",          bus.full,          ec == 8);
      check("empty",         bus.empty,         ec == 0);
      check("almost_full",   bus.almost_full,   ec >= 6);
      check("almost_empty",  bus.almost_empty,  ec <= 2);
      check("addr_a",        bus.addr_a,        wp);
      check("addr_b",        bus.addr_b,        rp);
      check("valid",         bus.valid,         er);
      check("err_overflow",  bus.err_overflow,  eovf);
      check("err_underflow", bus.err_underflow, eunf);
      if (er && exp_q.size() > 0) check("q_b", q_b, exp_q.pop_front());
   endtask

   // Reset cycle with an optional concurrent push that must not be written.
   task automatic do_reset(input logic p);
      @(negedge clk);
      reset    = 1'b1;
      bus.push = p;
      bus.pop  = 1'b0;
      wdata    = 4'hF;
      #1;
      check("rst_we_a", bus.we_a, 0);
      check("rst_re_b", bus.re_b, 0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      bus.push = 1'b0;
      check("rst_count",        bus.count,         0);
      check("rst_empty",        bus.empty,         1);
      check("rst_almost_empty", bus.almost_empty,  1);
      check("rst_full",         bus.full,          0);
      check("rst_almost_full",  bus.almost_full,   0);
      check("rst_addr_a",       bus.addr_a,        0);
      check("rst_addr_b",       bus.addr_b,        0);
      check("rst_valid",        bus.valid,         0);
      check("rst_err_ovf",      bus.err_overflow,  0);
      check("rst_err_unf",      bus.err_underflow, 0);
      store_q.delete();
      exp_q.delete();
      wp = '0;
      rp = '0;
   endtask

   initial begin
      reset    = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      wdata    = '0;
      wp       = '0;
      rp       = '0;
      for (int i = 0; i < 8; i++) mem[i] = '0;

      // Fill 1..8, overflow, drain, underflow, push+pop while empty, first word.
      for (int i = 1; i <= 8; i++) vecs.push_back('{1'b1, 1'b0, 4'(i), 1'b1, 1'b0, i, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 8, 1'b1, 1'b0});
      for (int i = 1; i <= 8; i++) vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 8 - i, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 0, 1'b1, 1'b1});

      do_reset(1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      foreach (vecs[i])
         step(vecs[i].push, vecs[i].pop, vecs[i].data, vecs[i].we, vecs[i].re,
              vecs[i].cnt, vecs[i].ovf, vecs[i].unf);

      // Error flags clear only on reset.
      do_reset(1'b0);

      // Wrap-around: push 5, pop 5, push 6 (write pointer wraps 7->0), drain 6.
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 4'(i), 1'b1, 1'b0, i, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5 - i, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 4'(9 + i), 1'b1, 1'b0, i, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 6 - i, 1'b0, 1'b0);

      // Push+pop while full keeps count at 8 and returns the oldest word.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 4'(i), 1'b1, 1'b0, i, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 8, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 8 - i, 1'b0, 1'b0);

      // Reset at count 5 with push held: everything clears, nothing written.
      do_reset(1'b1);
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
